// File: rtl/pipe_out_fifo.sv
// pipe_out_fifo: single-clock FIFO between the pipe-out data generator and the
// host block-throttled pipe-out endpoint.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous active-high reset, overrides every other input
//   pipe_out_write generator write strobe; pipe_out_data sampled with it
//   pipe_out_count registered occupancy, used by the generator to throttle
//   ep_read        endpoint read strobe; ep_data valid the cycle after acceptance
//   ep_ready       registered, high while occupancy >= BLOCK_WORDS
//   fifo_empty     registered, occupancy == 0
//   fifo_full      registered, occupancy == 2**ADDR_W-1
//   overflow       sticky, write attempted while full
//   underflow      sticky, read attempted while empty
//   clear_flags    clears overflow/underflow; a new error in the same cycle wins
module pipe_out_fifo #(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned BLOCK_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_out_write,
  input  logic [DATA_W-1:0] pipe_out_data,
  output logic [ADDR_W-1:0] pipe_out_count,
  input  logic              ep_read,
  output logic [DATA_W-1:0] ep_data,
  output logic              ep_ready,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              overflow,
  output logic              underflow,
  input  logic              clear_flags
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // One slot stays unused so occupancy fits in ADDR_W bits.
  localparam logic [ADDR_W-1:0] MaxCount = '1;
  localparam logic [ADDR_W-1:0] BlockCount = ADDR_W'(BLOCK_WORDS);

  logic [DATA_W-1:0] mem_q [Depth];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] ep_data_q, ep_data_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ready_q, ready_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic wr_acc;
  logic rd_acc;

  always_comb begin
    // Acceptance uses the registered flags, i.e. the state before the edge.
    wr_acc      = pipe_out_write & ~full_q;
    rd_acc      = ep_read & ~empty_q;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ep_data_d   = ep_data_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      ep_data_d = mem_q[rd_ptr_q];
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end

    // Status flags derive from the next count so they update with it.
    empty_d     = (count_d == '0);
    full_d      = (count_d == MaxCount);
    ready_d     = (count_d >= BlockCount);

    overflow_d  = (pipe_out_write & full_q) | (overflow_q & ~clear_flags);
    underflow_d = (ep_read & empty_q) | (underflow_q & ~clear_flags);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ep_data_q   <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ready_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ep_data_q   <= ep_data_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ready_q     <= ready_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= pipe_out_data;
    end
  end

  assign pipe_out_count = count_q;
  assign ep_data        = ep_data_q;
  assign ep_ready       = ready_q;
  assign fifo_empty     = empty_q;
  assign fifo_full      = full_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_pipe_out_fifo.sv
module tb_pipe_out_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_out_write;
  logic [63:0] pipe_out_data;
  logic [8:0]  pipe_out_count;
  logic        ep_read;
  logic [63:0] ep_data;
  logic        ep_ready;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic        underflow;
  logic        clear_flags;

  always #5 clk = ~clk;

  pipe_out_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_out_write (pipe_out_write),
    .pipe_out_data  (pipe_out_data),
    .pipe_out_count (pipe_out_count),
    .ep_read        (ep_read),
    .ep_data        (ep_data),
    .ep_ready       (ep_ready),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .overflow       (overflow),
    .underflow      (underflow),
    .clear_flags    (clear_flags)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of buffered words plus the last word handed out.
  logic [63:0] model_q[$];
  logic [63:0] model_data;
  logic        model_ovf;
  logic        model_udf;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, compare every output.
  task automatic cycle(input logic rst, input logic wr, input logic [63:0] d,
                       input logic rd, input logic clr);
    int  occ;
    bit  was_full;
    bit  was_empty;
    reset          = rst;
    pipe_out_write = wr;
    pipe_out_data  = d;
    ep_read        = rd;
    clear_flags    = clr;
    @(posedge clk);
    occ       = model_q.size();
    was_full  = (occ == 511);
    was_empty = (occ == 0);
    if (rst) begin
      model_q.delete();
      model_data = '0;
      model_ovf  = 1'b0;
      model_udf  = 1'b0;
    end else begin
      if (rd && !was_empty) model_data = model_q.pop_front();
      if (wr && !was_full) model_q.push_back(d);
      model_ovf = (wr && was_full) || (model_ovf && !clr);
      model_udf = (rd && was_empty) || (model_udf && !clr);
    end
    #1;
    occ = model_q.size();
    check_val("count", 64'(pipe_out_count), 64'(occ));
    check_val("empty", 64'(fifo_empty), 64'(occ == 0));
    check_val("full", 64'(fifo_full), 64'(occ == 511));
    check_val("ep_ready", 64'(ep_ready), 64'(occ >= 256));
    check_val("ep_data", ep_data, model_data);
    check_val("overflow", 64'(overflow), 64'(model_ovf));
    check_val("underflow", 64'(underflow), 64'(model_udf));
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    model_data = '0;
    model_ovf  = 1'b0;
    model_udf  = 1'b0;
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, rnd64(), 1'b1, 1'b1);
    check_val("rst_count", 64'(pipe_out_count), 64'd0);
    check_val("rst_empty", 64'(fifo_empty), 64'd1);
    check_val("rst_data", ep_data, 64'd0);

    // 1: fill to capacity, then one write too many
    for (int i = 1; i <= 511; i++) cycle(1'b0, 1'b1, 64'(i), 1'b0, 1'b0);
    check_val("t1_count", 64'(pipe_out_count), 64'd511);
    check_val("t1_full", 64'(fifo_full), 64'd1);
    check_val("t1_ready", 64'(ep_ready), 64'd1);
    check_val("t1_ovf0", 64'(overflow), 64'd0);
    cycle(1'b0, 1'b1, 64'd512, 1'b0, 1'b0);
    check_val("t1_ovf1", 64'(overflow), 64'd1);
    check_val("t1_count2", 64'(pipe_out_count), 64'd511);

    // 2: drain in order, then one read too many
    for (int i = 1; i <= 511; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
      check_val("t2_data", ep_data, 64'(i));
    end
    check_val("t2_empty", 64'(fifo_empty), 64'd1);
    check_val("t2_count", 64'(pipe_out_count), 64'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_val("t2_udf", 64'(underflow), 64'd1);
    check_val("t2_hold", ep_data, 64'd511);

    // 3: ep_ready threshold crossing in both directions
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 255; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    check_val("t3_ready0", 64'(ep_ready), 64'd0);
    cycle(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    check_val("t3_ready1", 64'(ep_ready), 64'd1);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_val("t3_ready_off", 64'(ep_ready), 64'd0);
    check_val("t3_count", 64'(pipe_out_count), 64'd255);

    // 4: simultaneous read+write when empty, mid-level and full
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 64'hA5, 1'b1, 1'b0);
    check_val("t4_cnt0", 64'(pipe_out_count), 64'd1);
    check_val("t4_udf", 64'(underflow), 64'd1);
    check_val("t4_ovf0", 64'(overflow), 64'd0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, rnd64(), 1'b1, 1'b0);
    check_val("t4_cnt10", 64'(pipe_out_count), 64'd10);
    check_val("t4_flags10", 64'({overflow, underflow}), 64'd0);
    for (int i = 0; i < 501; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, rnd64(), 1'b1, 1'b0);
    check_val("t4_cnt511", 64'(pipe_out_count), 64'd510);
    check_val("t4_ovf", 64'(overflow), 64'd1);
    check_val("t4_udf0", 64'(underflow), 64'd0);

    // 5: long stream with reads lagging writes, crossing pointer wrap many times
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2005; i++) begin
      cycle(1'b0, i < 2000, 64'(i) * 64'h0001_0001 + 64'h1000, i >= 5, 1'b0);
      check_val("t5_bound", 64'(pipe_out_count <= 9'd6), 64'd1);
    end
    check_val("t5_flags", 64'({overflow, underflow}), 64'd0);
    check_val("t5_last", ep_data, 64'd1999 * 64'h0001_0001 + 64'h1000);

    // 6: reset in the middle of a read burst
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, rnd64(), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    check_val("t6_count", 64'(pipe_out_count), 64'd0);
    check_val("t6_empty", 64'(fifo_empty), 64'd1);
    check_val("t6_ready", 64'(ep_ready), 64'd0);
    check_val("t6_data", ep_data, 64'd0);
    cycle(1'b0, 1'b1, 64'hDEADBEEF_01234567, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_val("t6_word", ep_data, 64'hDEADBEEF_01234567);

    // 7: randomized traffic with varying bias and occasional flag clears
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int chunk = 0; chunk < 6; chunk++) begin
      int unsigned wp = (chunk % 2 == 0) ? 85 : 25;
      int unsigned rp = (chunk % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 900; i++) begin
        cycle(1'b0, $urandom_range(0, 99) < wp, rnd64(), $urandom_range(0, 99) < rp,
              $urandom_range(0, 99) < 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
